ab_seq_arbiter: RTL and testbench

Round-robin controller that shares one `valid`/`a`/`b` handshake channel between `N_REQ` requesters. For each granted requester it issues one transaction whose outputs always satisfy the channel property `valid |=> (a ##GAP b)`. Transactions are serialized, so only one is in flight at a time. It sits in front of the block that consumes the handshake, and the team's concurrent-assertion checks are bound to its outputs.

---
 rtl/ab_seq_pkg.sv | 44 ++++
 rtl/ab_seq_arbiter_rr.sv | 47 ++++
 rtl/ab_seq_arbiter.sv | 131 +++++++++++++
 tb/tb_ab_seq_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ab_seq_pkg.sv
// ============================================================================
// ab_seq_pkg : shared state encoding and parameter limits for ab_seq_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package ab_seq_pkg;

    localparam int GAP_MIN   = 1;
    localparam int GAP_MAX   = 15;
    localparam int N_REQ_MAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_A_PH  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_B_PH  = 3'd4
    } ab_state_e;

    // Index width for a requester count, saturated at the supported maximum.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        if (n > N_REQ_MAX) begin
            return $clog2(N_REQ_MAX);
        end
        return $clog2(n);
    endfunction

    function automatic int clamp_gap(input int g);
        if (g < GAP_MIN) begin
            return GAP_MIN;
        end
        if (g > GAP_MAX) begin
            return GAP_MAX;
        end
        return g;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ab_seq_arbiter_rr.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, lowest index at/after pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import ab_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             any,
    output logic [N_REQ-1:0] onehot,
    output logic [IDW-1:0]   idx
);

    logic [IDW-1:0] w_cand [N_REQ];

    // Candidate i is (ptr + i) mod N_REQ; one extra bit keeps the sum exact.
    for (genvar i = 0; i < N_REQ; i++) begin : g_cand
        logic [IDW:0] w_sum;
        assign w_sum     = {1'b0, ptr} + (IDW+1)'(i);
        assign w_cand[i] = (w_sum >= (IDW+1)'(N_REQ)) ? IDW'(w_sum - (IDW+1)'(N_REQ))
                                                      : w_sum[IDW-1:0];
    end

    always_comb begin
        any    = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[w_cand[i]]) begin
                any = 1'b1;
                idx = w_cand[i];
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ab_seq_arbiter.sv
// ============================================================================
// ab_seq_arbiter : round-robin share of one valid/a/b channel, valid |=> a ##GAP b
// Rev 1.0
// ============================================================================
`default_nettype none

module ab_seq_arbiter
    import ab_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GAP   = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [N_REQ-1:0]            req,
    output logic [N_REQ-1:0]            gnt,
    output logic [idx_width(N_REQ)-1:0] gnt_id,
    output logic                        valid,
    output logic                        a,
    output logic                        b,
    output logic                        done,
    output logic                        busy
);

    localparam int c_idw = idx_width(N_REQ);
    localparam int c_gap = clamp_gap(GAP);
    localparam int c_cw  = $clog2(c_gap + 1);

    localparam logic [c_cw-1:0]  c_cnt_load = c_cw'(c_gap - 1);
    localparam logic [c_cw-1:0]  c_cnt_one  = c_cw'(1);
    localparam logic [c_idw-1:0] c_last     = c_idw'(N_REQ - 1);

    ab_state_e          r_state;
    logic [c_cw-1:0]    r_cnt;
    logic [c_idw-1:0]   r_ptr;

    logic               w_any;
    logic [N_REQ-1:0]   w_pick;
    logic [c_idw-1:0]   w_pick_id;
    logic [c_idw-1:0]   w_ptr_next;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (c_idw)
    ) u_rr (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .onehot (w_pick),
        .idx    (w_pick_id)
    );

    assign w_ptr_next = (gnt_id == c_last) ? '0 : gnt_id + c_idw'(1);

    // Every output is written here, so each is a flop loaded one state early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            valid   <= 1'b0;
            a       <= 1'b0;
            b       <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (enable && w_any) begin
                        gnt     <= w_pick;
                        gnt_id  <= w_pick_id;
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    valid   <= 1'b0;
                    a       <= 1'b1;
                    r_state <= ST_A_PH;
                end
                ST_A_PH: begin
                    a     <= 1'b0;
                    r_cnt <= c_cnt_load;
                    if (c_gap == 1) begin
                        b       <= 1'b1;
                        done    <= 1'b1;
                        r_state <= ST_B_PH;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Leaving at cnt==1 gives GAP-1 WAIT cycles and stops at zero.
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        b       <= 1'b1;
                        done    <= 1'b1;
                        r_state <= ST_B_PH;
                    end
                end
                ST_B_PH: begin
                    b       <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    gnt     <= '0;
                    gnt_id  <= '0;
                    r_ptr   <= w_ptr_next;
                    r_state <= ST_IDLE;
                end
                default: begin
                    valid   <= 1'b0;
                    a       <= 1'b0;
                    b       <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    gnt     <= '0;
                    gnt_id  <= '0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ab_seq_arbiter.sv
// ============================================================================
// tb_ab_seq_arbiter : vector table + scoreboard bench for ab_seq_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ab_seq_arbiter;

    localparam int N   = 4;
    localparam int GAP = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         valid, a, b, done, busy;

    logic         enable1 = 1'b0, enable15 = 1'b0;
    logic [N-1:0] req1 = '0, req15 = '0;
    logic [N-1:0] gnt1, gnt15;
    logic [1:0]   gnt_id1, gnt_id15;
    logic         valid1, a1, b1, done1, busy1;
    logic         valid15, a15, b15, done15, busy15;

    ab_seq_arbiter #(.N_REQ(N), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .gnt(gnt), .gnt_id(gnt_id),
        .valid(valid), .a(a), .b(b), .done(done), .busy(busy)
    );
    ab_seq_arbiter #(.N_REQ(N), .GAP(1)) dut_g1 (
        .clk(clk), .rst_n(rst_n), .enable(enable1), .req(req1), .gnt(gnt1), .gnt_id(gnt_id1),
        .valid(valid1), .a(a1), .b(b1), .done(done1), .busy(busy1)
    );
    ab_seq_arbiter #(.N_REQ(N), .GAP(15)) dut_g15 (
        .clk(clk), .rst_n(rst_n), .enable(enable15), .req(req15), .gnt(gnt15), .gnt_id(gnt_id15),
        .valid(valid15), .a(a15), .b(b15), .done(done15), .busy(busy15)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Channel property and exclusivity, on all three instances.
    a_va:   assert property (@(posedge clk) disable iff (!rst_n) valid |=> a)
        else begin failures++; $display("FAIL assert_valid_then_a cycle=%0d", cyc); end
    a_gap:  assert property (@(posedge clk) disable iff (!rst_n) b |-> $past(a, GAP))
        else begin failures++; $display("FAIL assert_a_gap_b cycle=%0d", cyc); end
    a_ex:   assert property (@(posedge clk) disable iff (!rst_n) !(a && b))
        else begin failures++; $display("FAIL assert_a_b_exclusive cycle=%0d", cyc); end
    a_vb:   assert property (@(posedge clk) disable iff (!rst_n) valid |-> !$past(busy))
        else begin failures++; $display("FAIL assert_valid_while_busy cycle=%0d", cyc); end
    a_bd:   assert property (@(posedge clk) disable iff (!rst_n) b == done)
        else begin failures++; $display("FAIL assert_b_eq_done cycle=%0d", cyc); end
    a_va1:  assert property (@(posedge clk) disable iff (!rst_n) valid1 |=> a1)
        else begin failures++; $display("FAIL assert_g1_valid_then_a cycle=%0d", cyc); end
    a_gap1: assert property (@(posedge clk) disable iff (!rst_n) b1 |-> $past(a1, 1))
        else begin failures++; $display("FAIL assert_g1_gap cycle=%0d", cyc); end
    a_ex1:  assert property (@(posedge clk) disable iff (!rst_n) !(a1 && b1) && (b1 == done1))
        else begin failures++; $display("FAIL assert_g1_excl cycle=%0d", cyc); end
    a_vb1:  assert property (@(posedge clk) disable iff (!rst_n) valid1 |-> !$past(busy1))
        else begin failures++; $display("FAIL assert_g1_valid_busy cycle=%0d", cyc); end
    a_va15: assert property (@(posedge clk) disable iff (!rst_n) valid15 |=> a15)
        else begin failures++; $display("FAIL assert_g15_valid_then_a cycle=%0d", cyc); end
    a_gp15: assert property (@(posedge clk) disable iff (!rst_n) b15 |-> $past(a15, 15))
        else begin failures++; $display("FAIL assert_g15_gap cycle=%0d", cyc); end
    a_ex15: assert property (@(posedge clk) disable iff (!rst_n) !(a15 && b15) && (b15 == done15))
        else begin failures++; $display("FAIL assert_g15_excl cycle=%0d", cyc); end
    a_vb15: assert property (@(posedge clk) disable iff (!rst_n) valid15 |-> !$past(busy15))
        else begin failures++; $display("FAIL assert_g15_valid_busy cycle=%0d", cyc); end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: expected grant ids, pushed when stimulus is driven.
    logic [1:0] exp_q[$];
    int valid_times[$];
    int valid_cnt = 0, a_cnt = 0, done_cnt = 0;
    int last_valid_cyc = 0, last_a_cyc = 0, last_b_cyc = 0;

    initial begin
        logic       pend_a, pend_b;
        logic [1:0] cur_id, e;
        logic [3:0] oh;
        pend_a = 1'b0;
        pend_b = 1'b0;
        cur_id = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_a = 1'b0;
                pend_b = 1'b0;
            end else begin
                if (valid) begin
                    valid_cnt++;
                    last_valid_cyc = cyc;
                    valid_times.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid: got id %0d expected no transaction", gnt_id);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = 4'b0001 << e;
                        check("grant_id", 32'(gnt_id), 32'(e));
                        check("grant_onehot", 32'(gnt), 32'(oh));
                    end
                    cur_id = gnt_id;
                    pend_a = 1'b1;
                end
                if (a) begin
                    a_cnt++;
                    check("valid_to_a", 32'(pend_a ? cyc - last_valid_cyc : -1), 1);
                    last_a_cyc = cyc;
                    pend_a = 1'b0;
                    pend_b = 1'b1;
                end
                if (b) begin
                    done_cnt++;
                    last_b_cyc = cyc;
                    check("a_to_b", 32'(pend_b ? cyc - last_a_cyc : -1), GAP);
                    check("done_with_b", 32'(done), 1);
                    check("gnt_id_stable", 32'(gnt_id), 32'(cur_id));
                    pend_b = 1'b0;
                end
            end
        end
    end

    int a1_cyc = 0, gap1_meas = 0, b1_seen = 0, a15_cyc = 0, gap15_meas = 0, b15_seen = 0;
    logic [3:0] gnt1_at_b = '0, gnt15_at_b = '0;
    logic [1:0] id1_at_b = '0, id15_at_b = '0;
    initial forever begin
        @(negedge clk);
        if (a1) a1_cyc = cyc;
        if (b1) begin
            gap1_meas = cyc - a1_cyc; b1_seen++; gnt1_at_b = gnt1; id1_at_b = gnt_id1;
        end
        if (a15) a15_cyc = cyc;
        if (b15) begin
            gap15_meas = cyc - a15_cyc; b15_seen++; gnt15_at_b = gnt15; id15_at_b = gnt_id15;
        end
    end

    task automatic wait_done(input int start, input string name);
        int n = 0;
        while (done_cnt == start && n < 40) begin
            step();
            n++;
        end
        check(name, done_cnt, start + 1);
    endtask

    task automatic wait_a(input int start, input string name);
        int n = 0;
        while (a_cnt == start && n < 20) begin
            step();
            n++;
        end
        check(name, a_cnt, start + 1);
    endtask

    typedef struct {
        logic [3:0] req;
        logic       grant;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[8];
    int sv, sd, t0, sb, n;

    initial begin
        vecs[0] = '{4'b0100, 1'b1, 2'd2};
        vecs[1] = '{4'b1001, 1'b1, 2'd3};
        vecs[2] = '{4'b1001, 1'b1, 2'd0};
        vecs[3] = '{4'b0110, 1'b1, 2'd1};
        vecs[4] = '{4'b0011, 1'b1, 2'd0};
        vecs[5] = '{4'b1000, 1'b1, 2'd3};
        vecs[6] = '{4'b0000, 1'b0, 2'd0};
        vecs[7] = '{4'b1110, 1'b1, 2'd1};

        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        check("reset_outputs", 32'({gnt, gnt_id, valid, a, b, done, busy}), 0);
        rst_n = 1'b1;

        // Single request straight out of reset, then pointer walk incl. wrap 3 -> 0.
        for (int i = 0; i < 8; i++) begin
            sv = valid_cnt;
            sd = done_cnt;
            if (vecs[i].grant) exp_q.push_back(vecs[i].id);
            req = vecs[i].req;
            t0  = cyc;
            if (vecs[i].grant) begin
                wait_done(sd, "vec_done");
                check("vec_latency", 32'(last_valid_cyc - t0), 1);
                check("vec_valid_count", valid_cnt, sv + 1);
            end else begin
                repeat (8) step();
                check("vec_idle_no_valid", valid_cnt, sv);
            end
            req = '0;
            step();
        end

        // Fairness from a fresh pointer with all requesters held.
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        valid_times.delete();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done(done_cnt, "fair_done");
        req = '0;
        check("fair_valid_count", valid_times.size(), 5);
        for (int k = 1; k < valid_times.size(); k++)
            check("fair_period", 32'(valid_times[k] - valid_times[k-1]), GAP + 3);
        step();

        // Enable gating, then enable dropped at the a cycle.
        enable = 1'b0;
        req    = 4'b0001;
        sv     = valid_cnt;
        repeat (20) step();
        check("gate_no_valid", valid_cnt, sv);
        exp_q.push_back(2'd0);
        sd     = done_cnt;
        enable = 1'b1;
        t0     = cyc;
        wait_a(a_cnt, "gate_a_seen");
        check("gate_latency", 32'(last_valid_cyc - t0), 1);
        enable = 1'b0;
        wait_done(sd, "gate_done");
        check("gate_a_to_b", 32'(last_b_cyc - last_a_cyc), GAP);
        sv = valid_cnt;
        repeat (6) step();
        check("gate_hold_idle", valid_cnt, sv);
        req    = '0;
        enable = 1'b1;
        step();

        // Request dropped during WAIT still completes.
        exp_q.push_back(2'd2);
        sd  = done_cnt;
        req = 4'b0100;
        wait_a(a_cnt, "drop_a_seen");
        step();
        check("drop_busy_in_wait", 32'(busy), 1);
        req = '0;
        wait_done(sd, "drop_req_done");
        step();

        // Asynchronous reset during WAIT, then a fresh sequence from requester 0.
        exp_q.push_back(2'd1);
        req = 4'b0010;
        wait_a(a_cnt, "rst_a_seen");
        step();
        check("pre_reset_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'({gnt, gnt_id, valid, a, b, done, busy}), 0);
        req = 4'b1111;
        repeat (2) step();
        exp_q.push_back(2'd0);
        sd    = done_cnt;
        rst_n = 1'b1;
        wait_done(sd, "post_reset_done");
        check("post_reset_valid_to_b", 32'(last_b_cyc - last_valid_cyc), GAP + 1);
        req = '0;
        step();

        // GAP boundaries on the dedicated instances.
        sb = b1_seen;
        enable1 = 1'b1;
        req1    = 4'b0001;
        n = 0;
        while (b1_seen == sb && n < 20) begin step(); n++; end
        req1 = '0;
        check("gap1_done", b1_seen, sb + 1);
        check("gap1_a_to_b", gap1_meas, 1);
        check("gap1_grant", 32'({gnt1_at_b, id1_at_b}), 32'({4'b0001, 2'd0}));

        sb = b15_seen;
        enable15 = 1'b1;
        req15    = 4'b1000;
        n = 0;
        while (b15_seen == sb && n < 40) begin step(); n++; end
        req15 = '0;
        check("gap15_done", b15_seen, sb + 1);
        check("gap15_a_to_b", gap15_meas, 15);
        check("gap15_grant", 32'({gnt15_at_b, id15_at_b}), 32'({4'b1000, 2'd3}));

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
